launch_sequencer: RTL and testbench

// - Next-generation launch controller: fires a channel start mask once all masked channels report armed and the trigger is high.
// - Adds a flat parametrised channel vector, N-shot repetition, programmable trigger-to-start delay, an arm timeout and abort.
// - Sits between the register file (config) and the DC/RF/LI waveform engines (armed in, start out).

---
 rtl/launch_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_launch_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/launch_sequencer.sv
// Launch sequencer: fires the latched channel mask once all masked channels are armed and the trigger is high.
// Optional LAUNCH_TRIG_SYNC_EN adds a 2-flop synchroniser on i_trigger (two extra cycles of latency).
module launch_sequencer #(
   parameter int NUM_CH = 33,
   parameter int SHOT_W = 16,
   parameter int DLY_W  = 16,
   parameter int TMO_W  = 24
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_cfg_load,
   input  logic [NUM_CH-1:0] i_cfg_mask,
   input  logic [SHOT_W-1:0] i_cfg_shots,
   input  logic [DLY_W-1:0]  i_cfg_delay,
   input  logic [TMO_W-1:0]  i_cfg_tmo,
   input  logic              i_abort,
   input  logic [NUM_CH-1:0] i_armed,
   input  logic              i_trigger,
   output logic [NUM_CH-1:0] o_start,
   output logic              o_busy,
   output logic              o_done,
   output logic [SHOT_W-1:0] o_shot_cnt,
   output logic              o_timeout,
   output logic              o_cfg_err
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_ARM = 3'd1,
      S_DELAY    = 3'd2,
      S_FIRE     = 3'd3,
      S_REARM    = 3'd4
   } state_t;

   localparam logic [SHOT_W-1:0] SHOT_ONE = {{(SHOT_W-1){1'b0}}, 1'b1};
   localparam logic [DLY_W-1:0]  DLY_ONE  = {{(DLY_W-1){1'b0}}, 1'b1};
   localparam logic [TMO_W-1:0]  TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [SHOT_W-1:0] shots_q, shots_d;
   logic [DLY_W-1:0]  delay_q, delay_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [NUM_CH-1:0] armed_q, armed_d;
   logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic [SHOT_W-1:0] shot_cnt_q, shot_cnt_d;
   logic [NUM_CH-1:0] start_q, start_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              timeout_q, timeout_d;
   logic              cfg_err_q, cfg_err_d;
   logic              trig_int_s;
   logic              ready_s;
   logic              qual_s;
   logic [SHOT_W-1:0] shot_inc_s;

`ifdef LAUNCH_TRIG_SYNC_EN
   logic trig_s1_q, trig_s2_q;

   // Two-flop synchroniser for an asynchronous trigger source.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         trig_s1_q <= 1'b0;
         trig_s2_q <= 1'b0;
      end else begin
         trig_s1_q <= i_trigger;
         trig_s2_q <= trig_s1_q;
      end
   end

   assign trig_int_s = trig_s2_q;
`else
   assign trig_int_s = i_trigger;
`endif

   // Exact match: an armed channel outside the mask blocks qualification.
   assign ready_s    = (armed_q == mask_q);
   assign qual_s     = ready_s && trig_int_s;
   assign shot_inc_s = shot_cnt_q + SHOT_ONE;

   // Next-state and output computation.
   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      shots_d    = shots_q;
      delay_d    = delay_q;
      tmo_d      = tmo_q;
      armed_d    = i_armed;
      dly_cnt_d  = dly_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      shot_cnt_d = shot_cnt_q;
      start_d    = '0;
      done_d     = 1'b0;
      timeout_d  = timeout_q;
      cfg_err_d  = cfg_err_q;

      if (i_abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_cfg_load) begin
                  if ((i_cfg_mask != '0) && (i_cfg_shots != '0)) begin
                     mask_d     = i_cfg_mask;
                     shots_d    = i_cfg_shots;
                     delay_d    = i_cfg_delay;
                     tmo_d      = i_cfg_tmo;
                     shot_cnt_d = '0;
                     tmo_cnt_d  = '0;
                     timeout_d  = 1'b0;
                     cfg_err_d  = 1'b0;
                     state_d    = S_WAIT_ARM;
                  end else begin
                     cfg_err_d = 1'b1;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_WAIT_ARM: begin
               // Qualification takes priority over a timeout expiring in the same cycle.
               if (qual_s) begin
                  dly_cnt_d = delay_q;
                  state_d   = S_DELAY;
               end else if ((tmo_q != '0) && (tmo_cnt_q == (tmo_q - TMO_ONE))) begin
                  timeout_d = 1'b1;
                  state_d   = S_IDLE;
               end else if (tmo_q != '0) begin
                  tmo_cnt_d = tmo_cnt_q + TMO_ONE;
               end else begin
                  tmo_cnt_d = tmo_cnt_q;
               end
            end
            S_DELAY: begin
               if (dly_cnt_q == '0) begin
                  state_d = S_FIRE;
               end else begin
                  dly_cnt_d = dly_cnt_q - DLY_ONE;
               end
            end
            S_FIRE: begin
               start_d    = mask_q;
               shot_cnt_d = shot_inc_s;
               if (shot_inc_s == shots_q) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_REARM;
               end
            end
            S_REARM: begin
               // Engines must drop armed before the next shot can qualify.
               if (armed_q != mask_q) begin
                  tmo_cnt_d = '0;
                  state_d   = S_WAIT_ARM;
               end else begin
                  state_d = S_REARM;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d = (state_d != S_IDLE) || (start_d != '0);
   end

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         mask_q     <= '0;
         shots_q    <= '0;
         delay_q    <= '0;
         tmo_q      <= '0;
         armed_q    <= '0;
         dly_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         shot_cnt_q <= '0;
         start_q    <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         shots_q    <= shots_d;
         delay_q    <= delay_d;
         tmo_q      <= tmo_d;
         armed_q    <= armed_d;
         dly_cnt_q  <= dly_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         shot_cnt_q <= shot_cnt_d;
         start_q    <= start_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign o_start    = start_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_shot_cnt = shot_cnt_q;
   assign o_timeout  = timeout_q;
   assign o_cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_launch_sequencer.sv
// Directed bench for launch_sequencer: expected start pulses are queued at stimulus time and
// compared by a negedge monitor when the DUT fires.
module tb_launch_sequencer;

   localparam int NUM_CH = 33;
`ifdef LAUNCH_TRIG_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cfg_load;
   logic [NUM_CH-1:0] cfg_mask;
   logic [15:0]       cfg_shots;
   logic [15:0]       cfg_delay;
   logic [23:0]       cfg_tmo;
   logic              abort;
   logic [NUM_CH-1:0] armed;
   logic              trigger;
   logic [NUM_CH-1:0] o_start;
   logic              o_busy;
   logic              o_done;
   logic [15:0]       o_shot_cnt;
   logic              o_timeout;
   logic              o_cfg_err;

   typedef struct {
      int                cyc;
      logic [NUM_CH-1:0] start;
      logic              done;
      logic [15:0]       cnt;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   launch_sequencer dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_cfg_load (cfg_load),
      .i_cfg_mask (cfg_mask),
      .i_cfg_shots(cfg_shots),
      .i_cfg_delay(cfg_delay),
      .i_cfg_tmo  (cfg_tmo),
      .i_abort    (abort),
      .i_armed    (armed),
      .i_trigger  (trigger),
      .o_start    (o_start),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_shot_cnt (o_shot_cnt),
      .o_timeout  (o_timeout),
      .o_cfg_err  (o_cfg_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int at, input logic [NUM_CH-1:0] m, input logic d, input logic [15:0] c);
      exp_t x;
      x.cyc   = at;
      x.start = m;
      x.done  = d;
      x.cnt   = c;
      sb.push_back(x);
   endtask

   task automatic wait_sb(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("start_arrived", 64'(sb.size()), 64'd0);
   endtask

   task automatic load(input logic [NUM_CH-1:0] m, input logic [15:0] s, input logic [15:0] d,
                       input logic [23:0] t);
      cfg_mask  = m;
      cfg_shots = s;
      cfg_delay = d;
      cfg_tmo   = t;
      cfg_load  = 1'b1;
      step(1);
      cfg_load  = 1'b0;
   endtask

   // Scoreboard monitor: every start pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && (o_start != '0 || o_done)) begin
         if (sb.size() == 0) begin
            check("unexpected_start", {o_done, o_start}, 64'd0);
         end else begin
            e = sb.pop_front();
            check("start_cycle", 64'(cyc), 64'(e.cyc));
            check("start_mask", o_start, e.start);
            check("done", o_done, e.done);
            check("shot_cnt", o_shot_cnt, e.cnt);
         end
      end
   end

   initial begin
      logic [NUM_CH-1:0] m;
      rst_n = 1'b0; cfg_load = 1'b0; cfg_mask = '0; cfg_shots = '0; cfg_delay = '0;
      cfg_tmo = '0; abort = 1'b0; armed = '0; trigger = 1'b0;
      step(3);
      check("rst_start", o_start, 64'd0);
      check("rst_busy", o_busy, 64'd0);
      check("rst_done", o_done, 64'd0);
      check("rst_shot", o_shot_cnt, 64'd0);
      check("rst_tmo", o_timeout, 64'd0);
      check("rst_err", o_cfg_err, 64'd0);
      rst_n = 1'b1;
      step(2);

      // Single shot, zero delay
      m = 33'h1_0000_0003;
      armed = m;
      load(m, 16'd1, 16'd0, 24'd0);
      step(2);
      push(cyc + 1 + LAT, m, 1'b1, 16'd1);
      trigger = 1'b1;
      wait_sb(40);
      check("busy_at_start", o_busy, 64'd1);
      @(negedge clk); #1;
      check("busy_after", o_busy, 64'd0);
      check("start_after", o_start, 64'd0);
      trigger = 1'b0;
      step(3);

      // Three shots, delay 5, armed toggled between shots
      m = 33'h0_F0F0_00FF;
      armed = m;
      load(m, 16'd3, 16'd5, 24'd0);
      step(3);
      for (int s = 1; s <= 3; s++) begin
         push(cyc + 1 + LAT + 5, m, (s == 3), 16'(s));
         trigger = 1'b1;
         wait_sb(60);
         trigger = 1'b0;
         armed = '0;
         step(4);
         armed = m;
         step(4);
      end
      check("three_shot_idle", o_busy, 64'd0);

      // Two shots with armed held high: no double fire
      m = 33'h1_8000_0001;
      armed = m;
      load(m, 16'd2, 16'd0, 24'd0);
      step(2);
      push(cyc + 1 + LAT, m, 1'b0, 16'd1);
      trigger = 1'b1;
      wait_sb(40);
      step(20);
      check("hold_shot_cnt", o_shot_cnt, 64'd1);
      check("hold_busy", o_busy, 64'd1);
      trigger = 1'b0;
      armed = '0;
      step(4);
      armed = m;
      step(4);
      push(cyc + 1 + LAT, m, 1'b1, 16'd2);
      trigger = 1'b1;
      wait_sb(40);
      step(3);

      // Arm timeout of 10 cycles
      armed = '0;
      load(33'h0_0000_00F0, 16'd1, 16'd0, 24'd10);
      step(9);
      check("tmo_not_yet", o_timeout, 64'd0);
      check("tmo_busy", o_busy, 64'd1);
      step(1);
      check("tmo_hit", o_timeout, 64'd1);
      check("tmo_idle", o_busy, 64'd0);
      step(2);

      // Extra unmasked armed bit blocks start until cleared
      m = 33'h0_0000_0003;
      armed = 33'h1_0000_0003;
      load(m, 16'd1, 16'd2, 24'd0);
      check("tmo_cleared", o_timeout, 64'd0);
      step(15);
      check("extra_busy", o_busy, 64'd1);
      check("extra_no_shot", o_shot_cnt, 64'd0);
      armed = m;
      push(cyc + 1 + 3 + 2, m, 1'b1, 16'd1);
      wait_sb(40);
      trigger = 1'b0;
      step(3);

      // Invalid load, then abort during DELAY
      load('0, 16'd1, 16'd0, 24'd0);
      check("cfg_err_set", o_cfg_err, 64'd1);
      check("cfg_err_idle", o_busy, 64'd0);
      m = 33'h0_0001_0000;
      armed = m;
      load(m, 16'd1, 16'd20, 24'd0);
      check("cfg_err_clear", o_cfg_err, 64'd0);
      step(2);
      trigger = 1'b1;
      step(LAT + 3);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      check("abort_idle", o_busy, 64'd0);
      step(30);
      trigger = 1'b0;
      abort = 1'b1;
      load('0, 16'd1, 16'd0, 24'd0);
      abort = 1'b0;
      check("abort_beats_load", o_cfg_err, 64'd0);
      step(2);

      // Asynchronous reset in the middle of DELAY
      load(m, 16'd1, 16'd20, 24'd0);
      step(2);
      trigger = 1'b1;
      step(LAT + 3);
      check("pre_reset_busy", o_busy, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outs", {o_busy, o_done, o_timeout, o_cfg_err, o_shot_cnt, o_start}, 64'd0);
      step(1);
      rst_n = 1'b1;
      trigger = 1'b0;
      step(30);

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
